// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole game logic: FSM state encoding,
// LFSR tap mask / default seed and the LFSR next-value helper.
package whack_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SPAWN,
      SHOW,
      HIT,
      MISS,
      GAP,
      DONE
   } state_t;

   // x^8 + x^6 + x^5 + x^4 + 1, bit 7 is the x^8 term
   localparam logic [7:0] LFSR_TAPS         = 8'hB8;
   localparam logic [7:0] LFSR_DEFAULT_SEED = 8'hA5;

   function automatic logic [7:0] lfsr_next(input logic [7:0] q);
      return {q[6:0], ^(q & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, one step per clk; loads seed while reset is low.
// No handshake: the value is simply sampled by the consumer when it needs one.
module lfsr8
   import whack_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] seed,
   output logic [7:0] q
);

   logic [7:0] q_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) q_q <= seed;
      else        q_q <= lfsr_next(q_q);
   end

   assign q = q_q;

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller: lights a pseudo-random mole per round, judges presses
// against a tick timeout, keeps saturating score/miss counts; outputs registered, 1-cycle whack latency.
module mole_round_ctrl
   import whack_pkg::*;
#(
   parameter int unsigned NUM_MOLES   = 4,
   parameter int unsigned SHOW_TICKS  = 8,
   parameter int unsigned ROUNDS      = 16,
   parameter int unsigned SCORE_WIDTH = 8,
   parameter logic [7:0]  LFSR_SEED   = LFSR_DEFAULT_SEED
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   tick_in,
   input  logic                   start,
   input  logic [NUM_MOLES-1:0]   btn,
   output logic [NUM_MOLES-1:0]   mole,
   output logic [SCORE_WIDTH-1:0] score,
   output logic [SCORE_WIDTH-1:0] misses,
   output logic                   hit_pulse,
   output logic                   miss_pulse,
   output logic                   game_over
);

   localparam int unsigned          IDX_W     = (NUM_MOLES > 1) ? $clog2(NUM_MOLES) : 1;
   localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = '1;

   state_t                 state_q, state_d;
   logic                   tick_prev_q;
   logic [NUM_MOLES-1:0]   btn_q;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [7:0]             tcnt_q, tcnt_d;
   logic [7:0]             round_q, round_d;
   logic [SCORE_WIDTH-1:0] score_q, score_d;
   logic [SCORE_WIDTH-1:0] misses_q, misses_d;
   logic [NUM_MOLES-1:0]   mole_q, mole_d;
   logic                   hit_q, miss_q, over_q;

   logic [7:0]             lfsr_q;
   logic                   tick;
   logic [NUM_MOLES-1:0]   press, lit;
   logic                   press_lit, press_unlit, timeout;
   logic [IDX_W-1:0]       cand, spawn_idx;

   lfsr8 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .seed  (LFSR_SEED),
      .q     (lfsr_q)
   );

   assign tick        = tick_in & ~tick_prev_q;
   assign press       = btn & ~btn_q;
   assign lit         = NUM_MOLES'(1) << idx_q;
   assign press_lit   = |(press & lit);
   assign press_unlit = |(press & ~lit);
   assign timeout     = tick && (tcnt_q == 8'(SHOW_TICKS - 1));

   // Modulo by a power of two is the low LFSR bits; never repeat the previous mole.
   assign cand      = IDX_W'(lfsr_q % NUM_MOLES);
   assign spawn_idx = (cand == idx_q) ? cand + IDX_W'(1) : cand;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      tcnt_d   = tcnt_q;
      round_d  = round_q;
      score_d  = score_q;
      misses_d = misses_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d  = SPAWN;
               score_d  = '0;
               misses_d = '0;
               round_d  = '0;
               tcnt_d   = '0;
            end
         end
         SPAWN: begin
            idx_d   = spawn_idx;
            tcnt_d  = '0;
            state_d = SHOW;
         end
         SHOW: begin
            if (tick) tcnt_d = tcnt_q + 8'd1;
            if (press_unlit)    state_d = MISS;
            else if (press_lit) state_d = HIT;
            else if (timeout)   state_d = MISS;
            if (state_d == HIT) begin
               round_d = round_q + 8'd1;
               score_d = (score_q == SCORE_MAX) ? score_q : score_q + 1'b1;
            end else if (state_d == MISS) begin
               round_d  = round_q + 8'd1;
               misses_d = (misses_q == SCORE_MAX) ? misses_q : misses_q + 1'b1;
            end
         end
         HIT, MISS: state_d = (round_q == 8'(ROUNDS)) ? DONE : GAP;
         GAP:       if (tick) state_d = SPAWN;
         default:   state_d = IDLE;
      endcase
   end

   // Outputs are computed from the state being entered so they change on the entry edge.
   assign mole_d = (state_d == SHOW) ? (NUM_MOLES'(1) << idx_d) : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         tick_prev_q <= 1'b0;
         btn_q       <= '0;
         idx_q       <= '0;
         tcnt_q      <= '0;
         round_q     <= '0;
         score_q     <= '0;
         misses_q    <= '0;
         mole_q      <= '0;
         hit_q       <= 1'b0;
         miss_q      <= 1'b0;
         over_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_prev_q <= tick_in;
         btn_q       <= btn;
         idx_q       <= idx_d;
         tcnt_q      <= tcnt_d;
         round_q     <= round_d;
         score_q     <= score_d;
         misses_q    <= misses_d;
         mole_q      <= mole_d;
         hit_q       <= (state_d == HIT);
         miss_q      <= (state_d == MISS);
         over_q      <= (state_d == DONE);
      end
   end

   assign mole       = mole_q;
   assign score      = score_q;
   assign misses     = misses_q;
   assign hit_pulse  = hit_q;
   assign miss_pulse = miss_q;
   assign game_over  = over_q;

endmodule
